// File: rtl/music_pkg.sv
// Shared types and constants for the music sequencer: FSM states, the pitch divider table
// (half-periods of C4..B4 at a 100 MHz clock) and the song ROM.
package music_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPlay,
        StGap,
        StDone
    } state_e;

    localparam int unsigned DIV_W = 18;

    // Index 0 is C4, index 11 is B4; each value is clk cycles per half period.
    localparam logic [DIV_W-1:0] PITCH_DIV [12] = '{
        18'd191113, 18'd180388, 18'd170262, 18'd160706,
        18'd151686, 18'd143172, 18'd135137, 18'd127552,
        18'd120393, 18'd113636, 18'd107258, 18'd101239
    };

    // Entry format: [5:2] pitch code (0 = rest, 1..12 = C4..B4), [1:0] duration code.
    localparam logic [5:0] SONG [32] = '{
        {4'd1,  2'd1}, {4'd0,  2'd0}, {4'd1,  2'd0}, {4'd8,  2'd0},
        {4'd8,  2'd0}, {4'd10, 2'd0}, {4'd10, 2'd0}, {4'd8,  2'd1},
        {4'd6,  2'd0}, {4'd6,  2'd0}, {4'd5,  2'd0}, {4'd5,  2'd0},
        {4'd3,  2'd0}, {4'd3,  2'd0}, {4'd1,  2'd1}, {4'd0,  2'd0},
        {4'd8,  2'd0}, {4'd8,  2'd0}, {4'd6,  2'd0}, {4'd6,  2'd0},
        {4'd5,  2'd0}, {4'd5,  2'd0}, {4'd3,  2'd1}, {4'd0,  2'd0},
        {4'd8,  2'd0}, {4'd8,  2'd0}, {4'd6,  2'd0}, {4'd6,  2'd0},
        {4'd5,  2'd0}, {4'd5,  2'd0}, {4'd3,  2'd1}, {4'd1,  2'd3}
    };

    // Rest and out-of-range codes map to 0, which keeps the tone generator silent.
    function automatic logic [DIV_W-1:0] pitch_div(input logic [3:0] pitch);
        if (pitch == 4'd0 || pitch > 4'd12) begin
            return '0;
        end
        return PITCH_DIV[pitch - 4'd1];
    endfunction

endpackage

// File: rtl/music_tone_gen.sv
// Programmable square-wave divider: speaker toggles every div cycles while enabled.
// Disabled or div == 0 holds the output low and clears the phase counter.
module music_tone_gen
    import music_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] div,
    output logic         speaker
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tone_q, tone_d;

    always_comb begin
        cnt_d  = cnt_q + W'(1);
        tone_d = tone_q;
        if (!en || div == '0) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (cnt_q == div - W'(1)) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    // Gate with en so the output drops the same cycle playback leaves PLAY.
    assign speaker = tone_q & en;

endmodule

// File: rtl/music_seq.sv
// Song sequencer: steps through the song ROM, playing each note then a silent gap.
// Define MUSIC_SEQ_LOOP_EN to replay the song forever instead of finishing with a done pulse.
module music_seq
    import music_pkg::*;
#(
    parameter int unsigned NOTE_TICKS = 12_500_000,
    parameter int unsigned GAP_TICKS  = 1_250_000,
    parameter int unsigned SONG_LEN   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    output logic       speaker,
    output logic       busy,
    output logic [4:0] note_idx,
    output logic       done
);

    localparam int unsigned BEAT_W = $clog2(4 * NOTE_TICKS);
    localparam int unsigned GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
    localparam logic [4:0]       LAST_IDX = 5'(SONG_LEN - 1);

    state_e             state_q, state_d;
    logic [4:0]         idx_q, idx_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         dur_q, dur_d;
    logic [5:0]         entry;
    logic [BEAT_W-1:0]  play_last;
    logic               tone_en;

    assign entry     = SONG[idx_q];
    assign play_last = BEAT_W'((32'(dur_q) + 32'd1) * NOTE_TICKS - 32'd1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        beat_d  = '0;
        gap_d   = '0;
        div_d   = div_q;
        dur_d   = dur_q;
        if (stop && state_q != StIdle) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !stop) begin
                        state_d = StLoad;
                        idx_d   = '0;
                    end
                end
                StLoad: begin
                    div_d   = pitch_div(entry[5:2]);
                    dur_d   = entry[1:0];
                    state_d = StPlay;
                end
                StPlay: begin
                    if (beat_q == play_last) begin
                        state_d = StGap;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
                StGap: begin
                    if (gap_q == GAP_LAST) begin
                        if (idx_q == LAST_IDX) begin
`ifdef MUSIC_SEQ_LOOP_EN
                            idx_d   = '0;
                            state_d = StLoad;
`else
                            state_d = StDone;
`endif
                        end else begin
                            idx_d   = idx_q + 5'd1;
                            state_d = StLoad;
                        end
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            beat_q  <= '0;
            gap_q   <= '0;
            div_q   <= '0;
            dur_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            div_q   <= div_d;
            dur_q   <= dur_d;
        end
    end

    assign tone_en  = (state_q == StPlay) && (div_q != '0);
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign note_idx = idx_q;

    music_tone_gen #(
        .W(DIV_W)
    ) u_tone (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (tone_en),
        .div    (div_q),
        .speaker(speaker)
    );

endmodule
